// File: rtl/icap_rb_pkg.sv
// Shared types, ICAP command constants and the ICAP byte bit-order helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icap_rb_pkg;

  // Readback sequencer states; the two TURN states realise the CSIB-high read turnaround
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_TURN_A = 3'd2,
    ST_TURN_B = 3'd3,
    ST_READ   = 3'd4,
    ST_DRAIN  = 3'd5
  } rb_state_t;

  localparam logic [31:0] ICAP_SYNC_WORD = 32'hAA995566;
  localparam logic [31:0] ICAP_NOOP      = 32'h20000000;
  localparam logic [31:0] ICAP_DUMMY     = 32'hFFFFFFFF;

  // ICAP expects each byte bit-reversed relative to bitstream file order
  function automatic logic [31:0] icap_bitswap(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        r[8*b+k] = v[8*b+7-k];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_rb_fifo.sv
// Synchronous show-ahead FIFO with a free-slot count for credit-based producers.
// Latency: one cycle from push to head visible; pop takes effect at the clock edge.
// Backpressure: none internally; producer must respect o_free, push while full is dropped.
module icap_rb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dat,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_free
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_free  = (AW+1)'(DEPTH) - r_cnt;
  assign o_dat   = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because occupancy gates visibility
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave occupancy unchanged
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // The read-credit scheme upstream guarantees no push ever lands on a full FIFO
  ap_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && o_full));

endmodule

// File: rtl/icap_readback_reader.sv
// ICAPE3 readback: writes a command packet to ICAP, turns it to read, streams N words back out.
// Latency: first data READ_LATENCY+1 cycles after the first read issue; zero-bubble at tready=1.
// Backpressure: xCmd_tready follows xIcapAvail in CMD; reads are credit-limited by FIFO free
// slots so xRb_tready stalls never overflow. Optional ICAP_RB_BITSWAP_EN bit-reverses each byte.
module icap_readback_reader
  import icap_rb_pkg::*;
#(
  parameter int READ_LATENCY = 3,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 24
) (
  input  logic             AxiBusClock,
  input  logic             xAxiBusReset_n,
  input  logic             xRbStart,
  input  logic [CNT_W-1:0] xRbWordCount,
  output logic             xRbBusy,
  output logic             xRbErr,
  input  logic [63:0]      xCmd_tdata,
  input  logic             xCmd_tvalid,
  input  logic             xCmd_tlast,
  output logic             xCmd_tready,
  output logic [31:0]      xRb_tdata,
  output logic             xRb_tvalid,
  output logic             xRb_tlast,
  input  logic             xRb_tready,
  output logic             xIcapCsib,
  output logic             xIcapRdwrb,
  output logic [31:0]      xIcapI,
  input  logic [31:0]      xIcapO,
  input  logic             xIcapAvail
);

  localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W  = $clog2(READ_LATENCY + 1);

  rb_state_t              r_state;
  rb_state_t              w_next_state;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       r_issued;
  logic [CNT_W-1:0]       r_captured;
  logic [CNT_W-1:0]       r_delivered;
  logic [READ_LATENCY-1:0] r_vld_sr;
  logic [INF_W-1:0]       r_inflight;
  logic                   r_err;

  logic                   w_start_ok;
  logic                   w_start_zero;
  logic                   w_cmd_rdy;
  logic                   w_cmd_hs;
  logic [31:0]            w_cmd_word;
  logic                   w_credit_ok;
  logic                   w_issue;
  logic                   w_capture;
  logic [31:0]            w_cap_dat;
  logic                   w_rb_hs;
  logic                   w_last_beat;
  logic                   w_fifo_empty;
  logic                   w_fifo_full;
  logic [FREE_W-1:0]      w_free;
  logic [31:0]            w_fifo_dat;
  logic                   w_unused_cmd_hi;

  // Upper command lane carries nothing for ICAP
  assign w_unused_cmd_hi = ^{xCmd_tdata[63:32], w_fifo_full};

  assign w_start_ok   = (r_state == ST_IDLE) && xRbStart && (xRbWordCount != '0);
  assign w_start_zero = (r_state == ST_IDLE) && xRbStart && (xRbWordCount == '0);

  assign w_cmd_rdy = (r_state == ST_CMD) && xIcapAvail;
  assign w_cmd_hs  = w_cmd_rdy && xCmd_tvalid;

`ifdef ICAP_RB_BITSWAP_EN
  assign w_cmd_word = icap_bitswap(xCmd_tdata[31:0]);
  assign w_cap_dat  = icap_bitswap(xIcapO);
`else
  assign w_cmd_word = xCmd_tdata[31:0];
  assign w_cap_dat  = xIcapO;
`endif

  // A read may issue only if every in-flight word plus this one still fits in the FIFO
  assign w_credit_ok = (w_free > FREE_W'(r_inflight));
  assign w_issue     = (r_state == ST_READ) && xIcapAvail && (r_issued < r_count) && w_credit_ok;
  assign w_capture   = r_vld_sr[READ_LATENCY-1];

  assign w_rb_hs     = xRb_tvalid && xRb_tready;
  assign w_last_beat = (r_delivered == (r_count - CNT_W'(1)));

  assign xRb_tvalid = !w_fifo_empty;
  assign xRb_tdata  = w_fifo_dat;
  assign xRb_tlast  = xRb_tvalid && w_last_beat;
  assign xRbErr     = r_err;

  icap_rb_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (AxiBusClock),
    .i_rst_n (xAxiBusReset_n),
    .i_push  (w_capture),
    .i_dat   (w_cap_dat),
    .i_pop   (w_rb_hs),
    .o_dat   (w_fifo_dat),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_free  (w_free)
  );

  // State register
  always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
    if (!xAxiBusReset_n) r_state <= ST_IDLE;
    else                 r_state <= w_next_state;
  end

  // Next-state: command write, two-cycle turnaround, credit-limited reads, then drain
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_next_state = ST_CMD;
      ST_CMD:    if (w_cmd_hs && xCmd_tlast) w_next_state = ST_TURN_A;
      ST_TURN_A: w_next_state = ST_TURN_B;
      ST_TURN_B: w_next_state = ST_READ;
      ST_READ:   if (r_issued == r_count) w_next_state = ST_DRAIN;
      ST_DRAIN:  if (w_rb_hs && w_last_beat && (r_inflight == '0) && (r_captured == r_count))
                   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // ICAP pins and status; RDWRB only moves in states where CSIB is held high
  always_comb begin
    xCmd_tready = w_cmd_rdy;
    xIcapCsib   = !(w_cmd_hs || w_issue);
    xIcapRdwrb  = (r_state == ST_TURN_B) || (r_state == ST_READ) || (r_state == ST_DRAIN);
    xIcapI      = w_cmd_hs ? w_cmd_word : 32'h0;
    xRbBusy     = (r_state != ST_IDLE);
  end

  // Request bookkeeping: word count, issue/capture/delivery counters, sticky error
  always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
    if (!xAxiBusReset_n) begin
      r_count     <= '0;
      r_issued    <= '0;
      r_captured  <= '0;
      r_delivered <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_count     <= xRbWordCount;
        r_issued    <= '0;
        r_captured  <= '0;
        r_delivered <= '0;
        r_err       <= 1'b0;
      end else begin
        if (w_start_zero) r_err       <= 1'b1;
        if (w_issue)      r_issued    <= r_issued + CNT_W'(1);
        if (w_capture)    r_captured  <= r_captured + CNT_W'(1);
        if (w_rb_hs)      r_delivered <= r_delivered + CNT_W'(1);
      end
    end
  end

  // Read-latency marker pipe and in-flight count; O is sampled as each marker leaves
  always_ff @(posedge AxiBusClock or negedge xAxiBusReset_n) begin
    if (!xAxiBusReset_n) begin
      r_vld_sr   <= '0;
      r_inflight <= '0;
    end else begin
      r_vld_sr <= (r_vld_sr << 1) | READ_LATENCY'(w_issue);
      case ({w_issue, w_capture})
        2'b10:   r_inflight <= r_inflight + INF_W'(1);
        2'b01:   r_inflight <= r_inflight - INF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_icap_readback_reader.sv
// Randomized scoreboard bench for icap_readback_reader with a behavioural ICAPE3 model.
module tb_icap_readback_reader;
  import icap_rb_pkg::*;

  localparam int LAT   = 3;
  localparam int DEPTH = 16;
  localparam int CW    = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] wcount;
  logic          busy, err;
  logic [63:0]   cmd_tdata;
  logic          cmd_tvalid, cmd_tlast, cmd_tready;
  logic [31:0]   rb_tdata;
  logic          rb_tvalid, rb_tlast, rb_tready;
  logic          csib, rdwrb;
  logic [31:0]   icap_i, icap_o;
  logic          avail;

  always #5 clk = ~clk;

  icap_readback_reader #(.READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .AxiBusClock    (clk),
    .xAxiBusReset_n (rst_n),
    .xRbStart       (start),
    .xRbWordCount   (wcount),
    .xRbBusy        (busy),
    .xRbErr         (err),
    .xCmd_tdata     (cmd_tdata),
    .xCmd_tvalid    (cmd_tvalid),
    .xCmd_tlast     (cmd_tlast),
    .xCmd_tready    (cmd_tready),
    .xRb_tdata      (rb_tdata),
    .xRb_tvalid     (rb_tvalid),
    .xRb_tlast      (rb_tlast),
    .xRb_tready     (rb_tready),
    .xIcapCsib      (csib),
    .xIcapRdwrb     (rdwrb),
    .xIcapI         (icap_i),
    .xIcapO         (icap_o),
    .xIcapAvail     (avail)
  );

  typedef struct { logic [31:0] d; logic l; } beat_t;
  typedef struct { logic [31:0] d; int due; } rd_t;

  beat_t       exp_q[$];
  logic [31:0] cmd_q[$];
  rd_t         rd_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int rd_issued = 0, delivered = 0, wr_count = 0;
  int last_wr_cyc = 0, first_rd_cyc = -1;
  int tready_mode = 0;
  logic [31:0] run_base = 32'h0;
  bit busy_chk_next = 0;
  bit stall_prev = 0;
  logic [31:0] stall_dat = 32'h0;
  logic prev_csib = 1'b1, prev_rdwrb = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference byte bit-order used by software-facing data when the swap build is selected
  function automatic logic [31:0] model_data(input logic [31:0] v);
`ifdef ICAP_RB_BITSWAP_EN
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        r[8*b+k] = v[8*b+7-k];
    return r;
`else
    return v;
`endif
  endfunction

  // ICAPE3 read model and output-side ready pattern, updated just after each rising edge
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      icap_o = rd_q[0].d;
      void'(rd_q.pop_front());
    end else begin
      icap_o = $urandom;
    end
    case (tready_mode)
      0:       rb_tready = 1'b1;
      1:       rb_tready = (cyc % 3 == 0);
      default: rb_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: samples mid-cycle, sees the values the DUT will act on at the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0; busy_chk_next = 0; prev_csib = 1'b1; prev_rdwrb = 1'b0;
    end else begin
      if (!csib && !rdwrb) begin
        wr_count++;
        last_wr_cyc = cyc;
        if (cmd_q.size() == 0) chk(0, "icap_write_extra", icap_i, 32'h0);
        else begin
          logic [31:0] e;
          e = cmd_q.pop_front();
          chk(icap_i == e, "icap_write_data", icap_i, e);
        end
      end
      if (!csib && rdwrb) begin
        chk(rd_issued - delivered + 1 <= DEPTH, "read_credit", rd_issued - delivered + 1, DEPTH);
        if (rd_issued == 0) first_rd_cyc = cyc;
        rd_q.push_back('{d: run_base + rd_issued, due: cyc + LAT});
        rd_issued++;
      end
      if (!avail) chk(csib == 1'b1, "csib_while_unavail", {31'b0, csib}, 32'h1);
      if (rdwrb != prev_rdwrb)
        chk(csib && prev_csib, "rdwrb_switch_csib_high", {30'b0, prev_csib, csib}, 32'h3);
      if (busy_chk_next) begin
        chk(busy == 1'b0, "busy_after_last", {31'b0, busy}, 32'h0);
        busy_chk_next = 0;
      end
      if (stall_prev)
        chk(rb_tvalid && rb_tdata == stall_dat, "axis_hold", rb_tdata, stall_dat);
      if (rb_tvalid && rb_tready) begin
        if (exp_q.size() == 0) chk(0, "rb_extra_beat", rb_tdata, 32'h0);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          chk(rb_tdata == b.d, "rb_data", rb_tdata, b.d);
          chk(rb_tlast == b.l, "rb_tlast", {31'b0, rb_tlast}, {31'b0, b.l});
        end
        delivered++;
        if (rb_tlast) begin
          chk(busy == 1'b1, "busy_at_last", {31'b0, busy}, 32'h1);
          busy_chk_next = 1;
        end
      end
      stall_prev = rb_tvalid && !rb_tready;
      stall_dat  = rb_tdata;
      prev_rdwrb = rdwrb;
      prev_csib  = csib;
    end
  end

  task automatic check_reset_values();
    chk(csib == 1'b1,       "rst_csib",   {31'b0, csib},       32'h1);
    chk(rdwrb == 1'b0,      "rst_rdwrb",  {31'b0, rdwrb},      32'h0);
    chk(icap_i == 32'h0,    "rst_icap_i", icap_i,              32'h0);
    chk(cmd_tready == 1'b0, "rst_tready", {31'b0, cmd_tready}, 32'h0);
    chk(rb_tvalid == 1'b0,  "rst_tvalid", {31'b0, rb_tvalid},  32'h0);
    chk(rb_tlast == 1'b0,   "rst_tlast",  {31'b0, rb_tlast},   32'h0);
    chk(busy == 1'b0,       "rst_busy",   {31'b0, busy},       32'h0);
    chk(err == 1'b0,        "rst_err",    {31'b0, err},        32'h0);
  endtask

  task automatic run(input int count, input int ncmd, input int mode, input int gap_at,
                     input logic [31:0] base, input bit chk_turn, input int abort_after);
    logic [31:0] cw[$];
    bit acc;
    int guard;
    tready_mode = mode; run_base = base;
    rd_issued = 0; delivered = 0; wr_count = 0; first_rd_cyc = -1;
    for (int i = 0; i < count; i++) exp_q.push_back('{d: model_data(base + i), l: (i == count - 1)});
    for (int i = 0; i < ncmd; i++) begin
      logic [31:0] w;
      w = (i == 0) ? ICAP_DUMMY : (i == 1) ? ICAP_SYNC_WORD : (i == 2) ? ICAP_NOOP : $urandom;
      cw.push_back(w);
      cmd_q.push_back(model_data(w));
    end
    @(posedge clk); #1;
    start = 1'b1; wcount = CW'(count);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk(busy == 1'b1, "busy_after_start", {31'b0, busy}, 32'h1);
    chk(err == 1'b0,  "err_after_start",  {31'b0, err},  32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < ncmd; i++) begin
      cmd_tdata  = {32'($urandom), cw[i]};
      cmd_tlast  = (i == ncmd - 1);
      cmd_tvalid = 1'b1;
      guard = 0;
      do begin
        @(negedge clk); acc = cmd_tready;
        @(posedge clk); #1; guard++;
      end while (!acc && guard < 200);
      if (!acc) chk(0, "cmd_accept_timeout", 32'(guard), 32'd200);
      cmd_tvalid = 1'b0; cmd_tlast = 1'b0;
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end
    if (gap_at >= 0) begin
      for (int i = 0; i < 500 && rd_issued < gap_at; i++) @(negedge clk);
      if (rd_issued < gap_at) chk(0, "gap_wait_timeout", 32'(rd_issued), 32'(gap_at));
      @(posedge clk); #1; avail = 1'b0;
      repeat (5) @(posedge clk);
      #1; avail = 1'b1;
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (abort_after > 0 && delivered >= abort_after) begin
        #2; rst_n = 1'b0;
        #1; check_reset_values();
        exp_q.delete(); cmd_q.delete(); rd_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (!busy && exp_q.size() == 0) break;
    end
    chk(!busy && exp_q.size() == 0, "run_done_timeout", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
    chk(wr_count == ncmd,  "write_pulses", 32'(wr_count), 32'(ncmd));
    chk(rd_issued == count, "read_pulses", 32'(rd_issued), 32'(count));
    if (chk_turn) chk(first_rd_cyc - last_wr_cyc == 3, "turnaround", 32'(first_rd_cyc - last_wr_cyc), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; wcount = '0;
    cmd_tdata = '0; cmd_tvalid = 1'b0; cmd_tlast = 1'b0;
    icap_o = '0; avail = 1'b1; rb_tready = 1'b1;
    #3;
    check_reset_values();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run(4,  6, 0, -1, 32'h1000_0000, 1, 0);
    run(64, 5, 1, -1, 32'h2000_0000, 0, 0);
    run(20, 4, 0,  6, 32'h3000_0000, 0, 0);

    @(posedge clk); #1; start = 1'b1; wcount = '0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk(err == 1'b1,        "zero_count_err",   {31'b0, err},        32'h1);
    chk(busy == 1'b0,       "zero_count_idle",  {31'b0, busy},       32'h0);
    chk(cmd_tready == 1'b0, "zero_count_ready", {31'b0, cmd_tready}, 32'h0);
    run(3, 3, 2, -1, 32'h4000_0000, 0, 0);

    run(32, 4, 0, -1, 32'h6000_0000, 0, 10);
    run(2,  3, 0, -1, 32'h5000_0000, 1, 0);
    run(1,  3, 0, -1, 32'h0102_0304, 0, 0);
    run($urandom_range(1, 40), 4, 2, -1, $urandom, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
